// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART transmitter among N_REQ
//            byte-stream requesters, with per-message lock and hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ        = 3,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 timeout_pulse
);

    localparam int c_PW = $clog2(N_REQ);
    localparam int c_HW = $clog2(HOLD_TIMEOUT);
    localparam logic [c_HW-1:0] c_HOLD_MAX = c_HW'(HOLD_TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_START = 2'd2;
    localparam logic [1:0] c_WAIT  = 2'd3;

    logic [1:0]       r_state,   w_state;
    logic [N_REQ-1:0] r_grant,   w_grant;
    logic [c_PW-1:0]  r_owner,   w_owner;
    logic [c_PW-1:0]  r_rr_ptr,  w_rr_ptr;
    logic [7:0]       r_tx_data, w_tx_data;
    logic             r_last,    w_last;
    logic [c_HW-1:0]  r_hold,    w_hold;

    logic             w_own_valid;
    logic [7:0]       w_own_data;
    logic             w_own_last;
    logic             w_any;
    logic [c_PW-1:0]  w_pick;
    int               w_idx;

    // Owner's request lines, selected by the one-hot grant
    always_comb begin
        w_own_valid = 1'b0;
        w_own_data  = 8'h00;
        w_own_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_valid = req_valid[i];
                w_own_data  = req_data[8*i +: 8];
                w_own_last  = req_last[i];
            end
        end
    end

    // Scan from farthest to nearest so the first valid after r_rr_ptr wins
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = c_PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state       = r_state;
        w_grant       = r_grant;
        w_owner       = r_owner;
        w_rr_ptr      = r_rr_ptr;
        w_tx_data     = r_tx_data;
        w_last        = r_last;
        w_hold        = r_hold;
        req_ready     = '0;
        tx_start      = 1'b0;
        timeout_pulse = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_grant = N_REQ'(1) << w_pick;
                    w_owner = w_pick;
                    w_hold  = '0;
                    w_state = c_LOAD;
                end
            end
            c_LOAD: begin
                req_ready = r_grant & req_valid;
                if (w_own_valid) begin
                    w_tx_data = w_own_data;
                    w_last    = w_own_last;
                    w_hold    = '0;
                    w_state   = c_START;
                end else if (r_hold == c_HOLD_MAX) begin
                    timeout_pulse = 1'b1;
                    w_rr_ptr      = r_owner;
                    w_grant       = '0;
                    w_hold        = '0;
                    w_state       = c_IDLE;
                end else begin
                    w_hold = r_hold + c_HW'(1);
                end
            end
            c_START: begin
                tx_start = 1'b1;
                w_state  = c_WAIT;
            end
            c_WAIT: begin
                if (tx_done) begin
                    if (r_last) begin
                        w_rr_ptr = r_owner;
                        w_grant  = '0;
                        w_state  = c_IDLE;
                    end else begin
                        w_hold  = '0;
                        w_state = c_LOAD;
                    end
                end
            end
            default: begin
                w_grant = '0;
                w_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= c_PW'(N_REQ - 1);
            r_tx_data <= 8'h00;
            r_last    <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_owner   <= w_owner;
            r_rr_ptr  <= w_rr_ptr;
            r_tx_data <= w_tx_data;
            r_last    <= w_last;
            r_hold    <= w_hold;
        end
    end

    assign grant   = r_grant;
    assign tx_data = r_tx_data;
    assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire
